// File: rtl/ceespu_regfile_sb.sv
// Parametrised register file with a per-register busy scoreboard and a post-reset clear sequence.
// Optional macro CEESPU_REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module ceespu_regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [ADDR_W-1:0] I_selA,
  input  logic [ADDR_W-1:0] I_selB,
  output logic [DATA_W-1:0] O_dataA,
  output logic [DATA_W-1:0] O_dataB,
  output logic              O_busyA,
  output logic              O_busyB,
  input  logic              I_we,
  input  logic [ADDR_W-1:0] I_selD,
  input  logic [DATA_W-1:0] I_dataD,
  input  logic              I_lock,
  input  logic [ADDR_W-1:0] I_selL,
  output logic              O_ready
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // One extra counter bit so the last-entry compare never wraps.
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(Depth - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e            stateQ;
  logic [ADDR_W:0]   clrCnt;
  logic [DATA_W-1:0] regs [Depth];
  logic [Depth-1:0]  busy;
  logic              wrEn;
  logic              lkEn;

  assign wrEn    = I_we && !(ZERO_REG != 0 && I_selD == '0);
  assign lkEn    = I_lock && !(ZERO_REG != 0 && I_selL == '0);
  assign O_ready = (stateQ == StReady);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      stateQ <= StClear;
      clrCnt <= '0;
      busy   <= '0;
    end else if (stateQ == StClear) begin
      regs[clrCnt[ADDR_W-1:0]] <= '0;
      clrCnt                   <= clrCnt + (ADDR_W + 1)'(1);
      if (clrCnt == LastIdx) stateQ <= StReady;
    end else begin
      if (wrEn) begin
        regs[I_selD] <= I_dataD;
        busy[I_selD] <= 1'b0;
      end
      // Issued after the write in this block so a same-cycle lock wins.
      if (lkEn) busy[I_selL] <= 1'b1;
    end
  end

  always_comb begin
    O_dataA = '0;
    O_busyA = 1'b0;
    if (stateQ == StReady) begin
      O_dataA = regs[I_selA];
      O_busyA = busy[I_selA];
`ifdef CEESPU_REGFILE_BYPASS_EN
      if (wrEn && I_selD == I_selA) begin
        O_dataA = I_dataD;
        O_busyA = lkEn && (I_selL == I_selA);
      end
`endif
      if (ZERO_REG != 0 && I_selA == '0) begin
        O_dataA = '0;
        O_busyA = 1'b0;
      end
    end
  end

  always_comb begin
    O_dataB = '0;
    O_busyB = 1'b0;
    if (stateQ == StReady) begin
      O_dataB = regs[I_selB];
      O_busyB = busy[I_selB];
`ifdef CEESPU_REGFILE_BYPASS_EN
      if (wrEn && I_selD == I_selB) begin
        O_dataB = I_dataD;
        O_busyB = lkEn && (I_selL == I_selB);
      end
`endif
      if (ZERO_REG != 0 && I_selB == '0) begin
        O_dataB = '0;
        O_busyB = 1'b0;
      end
    end
  end

endmodule

// File: doc/ceespu_regfile_sb.md
Name: ceespu_regfile_sb

Overview:
- Parametrised successor to the CPU register file: generic width and depth, optional hardwired zero register, and a per-register busy scoreboard for pipeline hazard detection.
- After every reset, a clear state machine zeroes all entries one per cycle.
- Sits between decode (read and lock) and writeback (write and unlock) in the ceespu pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, select width; depth = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 reads as zero, ignores writes and is never busy.

Ports:
- I_clk  in  1  clock, all state updates on rising edge.
- I_rst  in  1  synchronous, active-high reset.
- I_selA  in  ADDR_W  read port A select.
- I_selB  in  ADDR_W  read port B select.
- O_dataA  out  DATA_W  read data A, combinational.
- O_dataB  out  DATA_W  read data B, combinational.
- O_busyA  out  1  scoreboard busy bit of I_selA, combinational.
- O_busyB  out  1  scoreboard busy bit of I_selB, combinational.
- I_we  in  1  writeback enable.
- I_selD  in  ADDR_W  writeback select.
- I_dataD  in  DATA_W  writeback data.
- I_lock  in  1  mark register I_selL busy (instruction issued).
- I_selL  in  ADDR_W  lock select.
- O_ready  out  1  high when clear sequence is done and the file is usable.

Behaviour:
- Single clock I_clk. Reset I_rst is synchronous and active-high.
- States:
  - CLEAR: entered on any cycle with I_rst=1, including mid-operation; clear counter loads 0 and all busy bits clear at that edge.
  - CLEAR, each cycle with I_rst=0: entry[counter] <= 0, counter <= counter+1.
  - CLEAR exit: on the cycle that writes entry 2**ADDR_W-1, next state is READY. CLEAR lasts exactly 2**ADDR_W cycles after reset deasserts.
  - READY: stays until next I_rst.
- Counter is ADDR_W+1 bits so the last-entry compare cannot wrap.
- O_ready = (state==READY); it is 0 during and right after reset.
- In CLEAR:
  - I_we and I_lock are ignored.
  - O_dataA/B read 0.
  - O_busyA/B read 0.
- Write, READY only:
  - If I_we, entry[I_selD] <= I_dataD and busy[I_selD] <= 0 at the edge.
  - Value is visible on reads the cycle after (unless the bypass feature is enabled).
- Lock, READY only:
  - If I_lock, busy[I_selL] <= 1.
  - Same-cycle lock and write to the same register: the lock wins, busy=1, and data is still written (back-to-back issue after writeback).
  - Lock on an already-busy register stays 1; no counting.
- ZERO_REG=1:
  - Reads of select 0 return 0 and busy 0.
  - Writes and locks to 0 have no effect.
- ZERO_REG=0: entry 0 behaves like any other entry.
- Reads are asynchronous: O_dataX = entry[I_selX], O_busyX = busy[I_selX]. Both ports may select the same entry.
- Reset values:
  - O_ready=0.
  - O_dataA/B=0 and O_busyA/B=0 throughout CLEAR.
  - All entries are 0 once O_ready rises.
- No simulation-only initial blocks or $display; all clearing is done by the state machine.

Optional Feature:
- Macro: CEESPU_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding in READY.
  - If I_we and I_selD==I_selX (and not the zero register when ZERO_REG=1), O_dataX = I_dataD in the same cycle.
  - O_busyX = 0 in that cycle, unless I_lock targets the same register.
- Undefined: reads return the stored value; a same-cycle write is seen from the next cycle only.

Test Plan:
- Reset: hold I_rst 3 cycles, release with DATA_W=32, ADDR_W=5 -> O_ready rises exactly 32 cycles after release; every entry reads 0.
- Write/read: READY, write r5=0xDEADBEEF, next cycle selA=5, selB=5 -> both read 0xDEADBEEF. Write r0=0x1234 with ZERO_REG=1 -> r0 reads 0.
- Scoreboard: lock r7 -> O_busyA=1 for selA=7 next cycle. Write r7=42 -> busy=0 and data=42 next cycle. Same-cycle lock+write r7=99 -> busy=1, data=99.
- Mid-operation reset: fill r1..r3, lock r2, assert I_rst at CLEAR counter=10 -> busy cleared, counter restarts, O_ready after 32 more cycles, r1..r3 read 0.
- Writes during CLEAR: assert I_we r4=0x55 at counter=2 -> ignored, r4 reads 0 once ready.
- Bypass, macro defined: I_we r9=0xA5A5A5A5 with selA=9 same cycle -> O_dataA=0xA5A5A5A5 that cycle. Macro undefined -> O_dataA shows the old value that cycle, new value next cycle.
